digclock_set_ctrl: RTL and testbench
====================================

# digclock_set_ctrl

Front-panel time/alarm setting controller for the digital clock. Debounces two push-buttons (MODE, INC), walks an edit state machine over hour and minute fields for the clock time, then for the alarm, and drives the clock core's BCD set inputs and load strobes. It sits directly upstream of the clock core and feeds `H_in1/H_in0/M_in1/M_in0/LD_time/LD_alarm`. The load strobes are stretched so the core's slow internal tick always samples them.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a debounced level changes (≥1).
- `LD_HOLD`, default 12: cycles each load strobe is held high (≥ the core's 1 s tick period in `clk`).
- `REPEAT_CYCLES`, default 8: auto-repeat interval while INC is held (used only with the configuration macro).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `btn_mode`  in  1  raw MODE button, active-high, asynchronous.
- `btn_inc`  in  1  raw INC button, active-high, asynchronous.
- `H_in1`  out  2  hour tens digit (0–2).
- `H_in0`  out  4  hour units digit (0–9).
- `M_in1`  out  4  minute tens digit (0–5).
- `M_in0`  out  4  minute units digit (0–9).
- `LD_time`  out  1  time load strobe, high for `LD_HOLD` cycles.
- `LD_alarm`  out  1  alarm load strobe, high for `LD_HOLD` cycles.
- `edit_field`  out  2  0 = none, 1 = hour, 2 = minute (display blink select).
- `alarm_sel`  out  1  1 while editing or loading the alarm.

## Operation
- Each button passes through 2-flop synchronizer, then debouncer: counter counts consecutive cycles where synced ≠ debounced level, clears otherwise; on the `DEB_CYCLES`-th consecutive differing sample the debounced level flips. Press event = one-cycle rising edge of debounced level.
- Working registers: `hour` 5-bit binary 0–23, `minute` 6-bit binary 0–59. Outputs are combinational BCD splits of these, valid in every state.
- States: IDLE, T_HOUR, T_MIN, LOAD_T, A_HOUR, A_MIN, LOAD_A.
- MODE press: IDLE→T_HOUR→T_MIN→LOAD_T; A_HOUR→A_MIN→LOAD_A. LOAD_T→A_HOUR and LOAD_A→IDLE automatically after `LD_HOLD` cycles.
- INC press: in *_HOUR, hour = (hour==23) ? 0 : hour+1; in *_MIN, minute = (minute==59) ? 0 : minute+1; ignored in IDLE and LOAD states.
- `LD_time` high exactly in LOAD_T, `LD_alarm` exactly in LOAD_A; digit outputs frozen during LOAD states.
- Registers retain values across states (alarm editing starts from the just-loaded time).
- Simultaneous MODE and INC events: MODE acts, INC discarded.
- `edit_field`: 1 in T_HOUR/A_HOUR, 2 in T_MIN/A_MIN, else 0. `alarm_sel`: 1 in A_HOUR/A_MIN/LOAD_A.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, hour=0, minute=0, all outputs 0, debounced levels 0, all counters 0. Reset mid-LOAD aborts the strobe at that edge.
- Raw button rising and held: synchronizer 2 edges, debounce `DEB_CYCLES` edges, action 1 edge; state/register change visible after edge 3+`DEB_CYCLES` (edge 7 at default).
- Pulses shorter than `DEB_CYCLES` synchronized cycles produce no event.
- Strobe: first cycle in LOAD state has strobe=1; strobe falls and next state entered exactly `LD_HOLD` cycles later.
- Release is debounced identically; a new press needs a full release first.

## Configuration
- `SETCTRL_AUTOREPEAT_EN` defined: in *_HOUR/*_MIN, while debounced INC stays high, one additional increment every `REPEAT_CYCLES` cycles, counted from the press event; repeat counter clears on release, on state change, and on MODE event.
- Not defined: exactly one increment per press; repeat counter not built.

## Test plan
- Reset low 2 cycles, release -> all outputs 0, `edit_field`=0, digits 00:00.
- MODE held 6 cycles (default params) -> `edit_field`=1 after edge 7; 3-cycle glitch on `btn_mode` -> no state change.
- MODE, 23 INC presses in hour, 1 more -> `H_in1/H_in0` reaches 2/3 then wraps to 0/0.
- From 00:00: MODE, INC×13, MODE, INC×45, MODE -> `LD_time`=1 for exactly 12 cycles with digits 1/3/4/5, then `alarm_sel`=1, `edit_field`=1.
- Finish alarm edit with MODE -> `LD_alarm` high 12 cycles, then IDLE; MODE and INC events on same cycle in T_MIN -> state advances, minute unchanged.
- With `SETCTRL_AUTOREPEAT_EN`, INC held 40 cycles past press in T_MIN -> minute increases by 1+4=5; without macro -> by 1.

Source files
------------

// File: rtl/digclock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : digclock_set_ctrl
// Brief   : Front-panel time/alarm setting controller: debounced MODE/INC
//           buttons, hour/minute edit FSM, BCD set outputs, stretched loads.
//           Optional INC auto-repeat: define SETCTRL_AUTOREPEAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module digclock_set_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int LD_HOLD       = 12,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_field,
    output logic       alarm_sel
);

    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int LD_W     = $clog2(LD_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T_HOUR = 3'd1,
        S_T_MIN  = 3'd2,
        S_LOAD_T = 3'd3,
        S_A_HOUR = 3'd4,
        S_A_MIN  = 3'd5,
        S_LOAD_A = 3'd6
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] sync1_d, sync1_q;
    logic [1:0] sync2_d, sync2_q;
    logic [1:0] deb_d, deb_q;
    logic [1:0] deb_prev_d, deb_prev_q;
    logic       mode_ev;
    logic       inc_ev;
    logic       rep_fire;
    logic       in_edit;

    state_t           state_d, state_q;
    logic [4:0]       hour_d, hour_q;
    logic [5:0]       minute_d, minute_q;
    logic [LD_W-1:0]  ld_cnt_d, ld_cnt_q;

    assign btn_raw = {btn_inc, btn_mode};

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
    end

    // Per-button debouncer: level flips on the DEB_CYCLES-th consecutive
    // synchronized sample that disagrees with it.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [DEB_W-1:0] cnt_d, cnt_q;
        logic             deb_nx;

        always_comb begin
            cnt_d  = '0;
            deb_nx = deb_q[b];
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_nx = sync2_q[b];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign deb_d[b] = deb_nx;

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
        end
    end

    assign mode_ev = deb_q[BTN_MODE] & ~deb_prev_q[BTN_MODE];
    assign inc_ev  = deb_q[BTN_INC]  & ~deb_prev_q[BTN_INC];
    assign in_edit = (state_q == S_T_HOUR) || (state_q == S_T_MIN) ||
                     (state_q == S_A_HOUR) || (state_q == S_A_MIN);

`ifdef SETCTRL_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_d, rep_cnt_q;

    // Counts held-INC cycles since the press; any press, MODE event,
    // release or leaving the edit states restarts it from zero.
    always_comb begin
        rep_cnt_d = '0;
        rep_fire  = 1'b0;
        if (in_edit && deb_q[BTN_INC] && !mode_ev && !inc_ev) begin
            if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                rep_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        ld_cnt_d = '0;
        unique case (state_q)
            S_IDLE:   if (mode_ev) state_d = S_T_HOUR;
            S_T_HOUR: if (mode_ev) state_d = S_T_MIN;
            S_T_MIN:  if (mode_ev) state_d = S_LOAD_T;
            S_A_HOUR: if (mode_ev) state_d = S_A_MIN;
            S_A_MIN:  if (mode_ev) state_d = S_LOAD_A;
            S_LOAD_T, S_LOAD_A: begin
                if (ld_cnt_q == LD_W'(LD_HOLD - 1)) begin
                    state_d = (state_q == S_LOAD_T) ? S_A_HOUR : S_IDLE;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        // MODE wins over a coincident INC.
        if (in_edit && !mode_ev && (inc_ev || rep_fire)) begin
            if ((state_q == S_T_HOUR) || (state_q == S_A_HOUR)) begin
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                minute_d = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            hour_q   <= '0;
            minute_q <= '0;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    assign H_in1      = 2'(hour_q / 5'd10);
    assign H_in0      = 4'(hour_q % 5'd10);
    assign M_in1      = 4'(minute_q / 6'd10);
    assign M_in0      = 4'(minute_q % 6'd10);
    assign LD_time    = (state_q == S_LOAD_T);
    assign LD_alarm   = (state_q == S_LOAD_A);
    assign edit_field = ((state_q == S_T_HOUR) || (state_q == S_A_HOUR)) ? 2'd1 :
                        ((state_q == S_T_MIN)  || (state_q == S_A_MIN))  ? 2'd2 : 2'd0;
    assign alarm_sel  = (state_q == S_A_HOUR) || (state_q == S_A_MIN) ||
                        (state_q == S_LOAD_A);

endmodule
`default_nettype wire

// File: tb/tb_digclock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_digclock_set_ctrl
// Brief   : Table, hand-sequence and random-stimulus bench for the setting
//           controller, with a cycle-level behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_digclock_set_ctrl;

    localparam int DEB = 4;
    localparam int LDH = 12;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] edit_field;
    logic       alarm_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digclock_set_ctrl #(
        .DEB_CYCLES    (DEB),
        .LD_HOLD       (LDH),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .LD_alarm   (LD_alarm),
        .edit_field (edit_field),
        .alarm_sel  (alarm_sel)
    );

    // Behavioural model: step 0..6 = IDLE,T_HOUR,T_MIN,LOAD_T,A_HOUR,A_MIN,LOAD_A
    bit           m_s1 [2];
    bit           m_s2 [2];
    bit           m_deb [2];
    bit           m_prev [2];
    bit [DEB-1:0] m_sh [2];
    int           m_n [2];
    int           m_step, m_hour, m_min, m_load_left, m_rep_age;

    function automatic logic [31:0] pack(int h, int mi, bit lt, bit la, int ef, bit as);
        return {13'd0, 2'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), lt, la, 2'(ef), as};
    endfunction

    function automatic logic [31:0] act_vec();
        return {13'd0, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_field, alarm_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bump(input int step);
        if (step == 1 || step == 4) m_hour = (m_hour + 1) % 24;
        else                        m_min  = (m_min + 1) % 60;
    endtask

    task automatic model_step();
        bit raw [2];
        bit ev [2];
        bit held_inc;
        bit edit;
        int step0;
        raw[0] = btn_mode;
        raw[1] = btn_inc;
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0;
                m_sh[b] = '0; m_n[b] = 0;
            end
            m_step = 0; m_hour = 0; m_min = 0; m_load_left = 0; m_rep_age = 0;
            return;
        end
        held_inc = m_deb[1];
        for (int b = 0; b < 2; b++) begin
            ev[b]   = m_deb[b] && !m_prev[b];
            m_sh[b] = {m_sh[b][DEB-2:0], m_s2[b]};
            if (m_n[b] < DEB) m_n[b]++;
            m_prev[b] = m_deb[b];
            // Level changes once the last DEB samples all disagree with it.
            if (m_n[b] == DEB && m_sh[b] == (m_deb[b] ? {DEB{1'b0}} : {DEB{1'b1}}))
                m_deb[b] = !m_deb[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        step0 = m_step;
        edit  = (step0 == 1 || step0 == 2 || step0 == 4 || step0 == 5);
        if (step0 == 3 || step0 == 6) begin
            m_load_left--;
            if (m_load_left == 0) m_step = (step0 == 3) ? 4 : 0;
        end else if (ev[0]) begin
            m_step = step0 + 1;
            if (m_step == 3 || m_step == 6) m_load_left = LDH;
        end else if (ev[1] && edit) begin
            bump(step0);
        end
`ifdef SETCTRL_AUTOREPEAT_EN
        if (edit && held_inc && !ev[0] && !ev[1]) begin
            m_rep_age++;
            if (m_rep_age % REP == 0) bump(step0);
        end else begin
            m_rep_age = 0;
        end
`else
        m_rep_age = held_inc ? m_rep_age : 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", act_vec(),
            pack(m_hour, m_min, m_step == 3, m_step == 6,
                 (m_step == 1 || m_step == 4) ? 1 : (m_step == 2 || m_step == 5) ? 2 : 0,
                 m_step >= 4));
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        repeat (6) tick();
        btn_mode = 0;
        btn_inc  = 0;
        repeat (10) tick();
    endtask

    // MODE press into a LOAD state; returns strobe length and digits on its first cycle.
    task automatic measure(input bit alarm, output int len, output logic [15:0] digits);
        bit s;
        len    = 0;
        digits = 16'hffff;
        btn_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if (i == 6) btn_mode = 0;
            tick();
            s = alarm ? LD_alarm : LD_time;
            if (s) begin
                if (len == 0) digits = {2'b0, H_in1, H_in0, M_in1, M_in0};
                len++;
            end
        end
    endtask

    typedef struct {
        bit m;
        bit i;
        int n;
        int h;
        int mi;
        int ef;
        bit as;
        bit ldt;
    } vec_t;

    vec_t tbl [12];

    task automatic run_table(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            for (int r = 0; r < tbl[k].n; r++) press(tbl[k].m, tbl[k].i);
            chk($sformatf("table[%0d]", k), act_vec(),
                pack(tbl[k].h, tbl[k].mi, tbl[k].ldt, 1'b0, tbl[k].ef, tbl[k].as));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          len;
        logic [15:0] dig;

        tbl[0]  = '{0, 1, 23, 23,  0, 1, 0, 0};
        tbl[1]  = '{0, 1,  1,  0,  0, 1, 0, 0};
        tbl[2]  = '{0, 1, 13, 13,  0, 1, 0, 0};
        tbl[3]  = '{1, 0,  1, 13,  0, 2, 0, 0};
        tbl[4]  = '{0, 1, 45, 13, 45, 2, 0, 0};
        tbl[5]  = '{0, 1, 11,  0, 45, 1, 1, 0};
        tbl[6]  = '{1, 0,  1,  0, 45, 2, 1, 0};
        tbl[7]  = '{0, 1, 15,  0,  0, 2, 1, 0};
        tbl[8]  = '{0, 1,  1,  0,  0, 0, 0, 0};
        tbl[9]  = '{1, 0,  1,  0,  0, 1, 0, 0};
        tbl[10] = '{1, 0,  1,  0,  0, 2, 0, 0};
        tbl[11] = '{1, 1,  1,  0,  0, 0, 0, 1};

        reset = 0;
        repeat (2) tick();
        reset = 1;
        tick();
        chk("reset_outputs", act_vec(), 32'd0);

        btn_mode = 1;
        repeat (3) tick();
        btn_mode = 0;
        repeat (12) tick();
        chk("glitch_ignored", 32'(edit_field), 32'd0);

        btn_mode = 1;
        repeat (6) tick();
        chk("mode_before_edge7", 32'(edit_field), 32'd0);
        btn_mode = 0;
        tick();
        chk("mode_at_edge7", 32'(edit_field), 32'd1);
        repeat (10) tick();

        run_table(0, 4);

        measure(1'b0, len, dig);
        chk("ld_time_len", 32'(len), 32'd12);
        chk("ld_time_digits", 32'(dig), 32'h1345);
        chk("after_ld_time", {30'd0, alarm_sel, edit_field == 2'd1}, 32'd3);

        run_table(5, 7);

        measure(1'b1, len, dig);
        chk("ld_alarm_len", 32'(len), 32'd12);
        chk("ld_alarm_digits", 32'(dig), 32'h0000);
        chk("after_ld_alarm", {29'd0, alarm_sel, edit_field, LD_alarm}, 32'd0);

        run_table(8, 11);

        repeat (20) tick();
        press(1, 0);
        btn_inc = 1;
        repeat (40) tick();
        btn_inc = 0;
        repeat (15) tick();
`ifdef SETCTRL_AUTOREPEAT_EN
        chk("inc_held_40", {24'd0, M_in1, M_in0}, 32'h05);
`else
        chk("inc_held_40", {24'd0, M_in1, M_in0}, 32'h01);
`endif

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset = 0;
                repeat ($urandom_range(1, 2)) tick();
                reset = 1;
            end else begin
                btn_mode = ($urandom_range(0, 3) == 0);
                btn_inc  = $urandom_range(0, 1) != 0;
                repeat ($urandom_range(1, 14)) tick();
            end
        end
        btn_mode = 0;
        btn_inc  = 0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
